// File: rtl/soc_system_pio_out_pulse_if.sv
// -----------------------------------------------------------------------------
// soc_system_pio_out_pulse_if
//   Avalon-MM slave bus bundle for the output PIO with pulse generator.
//
//   address    : word address, 3 bits (register select)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (driven by the slave)
// -----------------------------------------------------------------------------
interface soc_system_pio_out_pulse_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_pio_out_pulse.sv
// -----------------------------------------------------------------------------
// soc_system_pio_out_pulse
//   Avalon-MM output PIO. Software writes DATA (or sets/clears bits atomically
//   through OUTSET/OUTCLEAR) and the value is held on out_port. A pulse engine
//   raises masked bits for PULSE_LEN clock cycles and clears them by itself.
//
//   Register map (word address):
//     0 DATA      R/W  output value
//     1 PULSE_LEN R/W  pulse length in clk cycles
//     2 PULSE     W: pulse mask   R: {count[31:16], 15'b0, busy}
//     4 OUTSET    W: DATA |= mask (reads 0)
//     5 OUTCLEAR  W: DATA &= ~mask (reads 0)
//     3, 6, 7     reserved (read 0, writes ignored)
//
//   Ports:
//     clk      : system clock, rising edge
//     reset_n  : synchronous active-low reset
//     bus      : Avalon-MM slave bundle (address/chipselect/write_n/
//                writedata/readdata)
//     out_port : DATA register, straight from flops
// -----------------------------------------------------------------------------
module soc_system_pio_out_pulse #(
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    soc_system_pio_out_pulse_if.slave bus,
    output logic [DATA_WIDTH-1:0]     out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_LEN      = 3'd1;
    localparam logic [2:0] ADDR_PULSE    = 3'd2;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    // Pulse engine state: idle or running a pulse ("busy").
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_PULSE = 1'b1;

    localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

    // Registered state
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] len_q;
    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] pmask_q;
    logic [0:0]            state_q;
    logic [31:0]           readdata_q;

    // Next-state values
    logic [DATA_WIDTH-1:0] data_n;
    logic [DATA_WIDTH-1:0] len_n;
    logic [DATA_WIDTH-1:0] count_n;
    logic [DATA_WIDTH-1:0] pmask_n;
    logic [0:0]            state_n;
    logic [31:0]           readdata_n;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] mask;
    logic                  pulse_fire;

    // Upper writedata bits beyond DATA_WIDTH carry no meaning.
    logic                  unused_writedata;

    assign wr_en            = bus.chipselect && !bus.write_n;
    assign mask             = bus.writedata[DATA_WIDTH-1:0];
    assign unused_writedata = ^bus.writedata;

    // A PULSE write only takes effect with a non-zero length; a zero length
    // discards it completely, so a running pulse keeps going untouched.
    assign pulse_fire = wr_en && (bus.address == ADDR_PULSE) && (len_q != '0);

    // -------------------------------------------------------------------------
    // Next-state logic. Ordering inside this block encodes the priority:
    // expiry clear first, then whatever register write happens this cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block is given a default
        // before any branch, otherwise an untaken path infers a latch.
        data_n  = data_q;
        len_n   = len_q;
        count_n = count_q;
        pmask_n = pmask_q;
        state_n = state_q;

        // Countdown / expiry. A pulse write in the expiry cycle is a
        // retrigger, so the clear is skipped in that case.
        if (state_q == ST_PULSE && !pulse_fire) begin
            if (count_q == CNT_ONE) begin
                data_n  = data_q & ~pmask_q;
                pmask_n = '0;
                count_n = '0;
                state_n = ST_IDLE;
            end else begin
                count_n = count_q - CNT_ONE;
            end
        end

        // Register writes are applied on top of the expiry result.
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_n = mask;
                ADDR_LEN:      len_n  = mask;
                ADDR_OUTSET:   data_n = data_n | mask;
                ADDR_OUTCLEAR: data_n = data_n & ~mask;
                ADDR_PULSE: begin
                    if (pulse_fire) begin
                        data_n  = data_n | mask;
                        pmask_n = (state_q == ST_PULSE) ? (pmask_q | mask) : mask;
                        count_n = len_q;
                        state_n = ST_PULSE;
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read mux. It selects from the next-state values so that the registered
    // readdata shows the register contents as they stand after the edge that
    // loads it (a write on edge T is readable right after T).
    // -------------------------------------------------------------------------
    always_comb begin
        readdata_n = '0;
        case (bus.address)
            ADDR_DATA:  readdata_n[DATA_WIDTH-1:0] = data_n;
            ADDR_LEN:   readdata_n[DATA_WIDTH-1:0] = len_n;
            ADDR_PULSE: begin
                readdata_n[0]               = (state_n == ST_PULSE);
                readdata_n[16 +: DATA_WIDTH] = count_n;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers with synchronous active-low reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (!reset_n) begin
            // NOTE: every flop here is reset, including pmask/count, so an
            // aborted pulse leaves nothing behind to expire later.
            data_q     <= RESET_VALUE;
            len_q      <= '0;
            count_q    <= '0;
            pmask_q    <= '0;
            state_q    <= ST_IDLE;
            readdata_q <= '0;
        end else begin
            data_q     <= data_n;
            len_q      <= len_n;
            count_q    <= count_n;
            pmask_q    <= pmask_n;
            state_q    <= state_n;
            readdata_q <= readdata_n;
        end
    end

    assign out_port     = data_q;
    assign bus.readdata = readdata_q;

endmodule

// File: doc/soc_system_pio_out_pulse.md
# soc_system_pio_out_pulse

Avalon-MM slave output PIO that drives a parallel output port from software-written registers. It adds atomic bit set/clear and a hardware-timed pulse generator. It is the write-direction counterpart to the system's read-only input PIOs: the HPS/QNX driver writes lamp and actuator states, and the block holds them on `out_port`. Timed pulses self-clear without software involvement.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of `out_port` and of the data, mask and pulse-length fields (1..16).
- `RESET_VALUE`, 0: value loaded into DATA on reset.

Ports:
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `reset_n`, input, 1: reset is synchronous and active-low.
- `address`, input, 3: register select.
- `chipselect`, input, 1: slave select.
- `write_n`, input, 1: active-low write strobe; a write occurs when `chipselect`=1 and `write_n`=0.
- `writedata`, input, 32: write data; bits above `DATA_WIDTH` are ignored.
- `readdata`, output, 32: registered read data.
- `out_port`, output, `DATA_WIDTH`: the DATA register, driven directly from flops.

## Operation
Register map (word addresses):
- 0 DATA, R/W: the output value.
- 1 PULSE_LEN, R/W: pulse duration in clk cycles, unsigned `DATA_WIDTH` bits.
- 2 PULSE:
  - Write: `writedata[DATA_WIDTH-1:0]` is the pulse mask.
  - Read: bit0 = busy, bits[31:16] = remaining count, all other bits 0.
- 3 reserved: reads 0, writes ignored.
- 4 OUTSET, W: DATA |= mask. Reads 0.
- 5 OUTCLEAR, W: DATA &= ~mask. Reads 0.
- 6, 7 reserved: read 0, writes ignored.

Pulse engine state: `busy`, `count[DATA_WIDTH-1:0]`, `pmask[DATA_WIDTH-1:0]`.
- PULSE write with PULSE_LEN=0: discarded; no state changes.
- PULSE write with PULSE_LEN=L>0 while idle:
  - DATA |= mask, pmask = mask, count = L, busy = 1.
- PULSE write while busy (retrigger):
  - DATA |= mask, pmask |= mask, count reloaded to current PULSE_LEN, busy stays 1.
  - If PULSE_LEN=0, the write is discarded and the running pulse continues.
- Each cycle while busy with no PULSE write:
  - count > 1: count decrements.
  - count == 1 (expiry): DATA &= ~pmask, pmask = 0, count = 0, busy = 0.
- A write to PULSE_LEN during a pulse does not affect the running count.
- Same-cycle priority on DATA: the expiry clear is applied first, then any register write in that cycle. The write wins.
  - Example: OUTSET of a pmask bit in the expiry cycle leaves that bit 1.
  - Example: a DATA write in the expiry cycle sets DATA to exactly `writedata`.
- A PULSE write in the expiry cycle counts as a retrigger. busy stays 1, the expiry clear is skipped, and pmask |= mask.
- Reset:
  - DATA = `RESET_VALUE`, PULSE_LEN = 0, busy = 0, count = 0, pmask = 0, `readdata` = 0.
  - Reset asserted mid-pulse aborts the pulse; DATA takes `RESET_VALUE`.
  - Reset has priority over all writes.

## Timing
- `readdata` is registered. It reflects the register selected by `address` one clk after that address is presented.
  - It is updated every cycle regardless of `chipselect`, so read latency is 1.
  - Reads have no side effects.
- A write accepted on edge T is visible on `out_port` and in read data after edge T. There are no wait states.
- Pulse of length L started by a PULSE write on edge T: the masked bits are high from edge T to edge T+L, exactly L cycles. They are low after edge T+L.
- PULSE read of busy and count shows the state after the most recent edge.
- All outputs are glitch-free flop outputs with no combinational path from inputs.

## Test plan
- Reset, then read addresses 0 to 7 → `out_port`=0x0000 and every read returns 0.
- Write DATA=0x00A5, then OUTSET 0x0F00, then OUTCLEAR 0x0005 → `out_port` is 0x00A5, then 0x0FA5, then 0x0FA0; reading address 0 returns 0x00000FA0.
- PULSE_LEN=5, PULSE mask 0x0003 on edge T → bits[1:0] high for exactly 5 cycles, low after edge T+5. A PULSE read at T+2 returns 0x00030001 (count 3, busy 1).
- PULSE_LEN=4, pulse mask 0x0001, retrigger with mask 0x0002 after 2 cycles → bit0 stays high, both bits clear together 4 cycles after the retrigger.
- PULSE_LEN=3, pulse mask 0x0010, OUTSET 0x0010 in the expiry cycle → bit4 remains 1 and busy becomes 0.
- PULSE_LEN=0 with a PULSE write → no change, busy 0. Then PULSE_LEN=10, a pulse, and `reset_n` low at cycle 4 → `out_port`=`RESET_VALUE` and busy=0 on the next edge.
